muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have no parameters; the datapath width is fixed at 32 bits.
REQ-002 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 start  input  1  request to begin an operation; it SHALL be honoured only in IDLE.
REQ-005 funct3  input  3  operation select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 rs1_val  input  32  first operand, taken from the register file rs1 read port.
REQ-007 rs2_val  input  32  second operand, taken from the register file rs2 read port.
REQ-008 rd_in  input  5  destination register index for the operation.
REQ-009 busy  output  1  high while an operation is computing; the core SHALL stall its PC and register-file write while busy is high.
REQ-010 done  output  1  one-cycle pulse that marks result and rd_out as valid for the register-file write port.
REQ-011 result  output  32  operation result, to be driven onto the register file rd_din.
REQ-012 rd_out  output  5  latched copy of rd_in, to be driven onto the register file rd.

Function
REQ-013 The FSM SHALL have three states, with these transitions:
- IDLE to CALC on start.
- CALC to DONE when the iteration counter reaches 31.
- DONE to IDLE unconditionally.
REQ-014 On the accepting edge N the block SHALL do all of the following:
- latch funct3, rd_in, and the magnitudes and signs of both operands;
- clear the 5-bit counter;
- enter CALC.
REQ-015 busy SHALL be high exactly in CALC, which lasts 32 cycles (after edges N through N+31).
REQ-016 done SHALL be high exactly in DONE, i.e. for the single cycle after edge N+32, with result and rd_out valid in that cycle.
REQ-017 After done, result and rd_out SHALL hold their values until the next accepted start or reset.
REQ-018 start SHALL be ignored in CALC and in DONE, and operand or funct3 changes after acceptance SHALL have no effect.
REQ-019 The earliest back-to-back start SHALL be accepted on the edge that returns the FSM to IDLE plus one cycle, giving a minimum initiation interval of 34 cycles.
REQ-020 Multiply SHALL be computed as a 32-iteration shift-add on operand magnitudes, producing a 64-bit product, then negated if the operand signs differ.
- MULH treats both operands as signed.
- MULHSU treats rs1 as signed and rs2 as unsigned.
- MULHU and MUL treat both operands as unsigned.
REQ-021 MUL SHALL return product[31:0]; MULH, MULHSU and MULHU SHALL return product[63:32].
REQ-022 Divide SHALL use 32-iteration restoring division on magnitudes.
- DIV and REM operands are signed.
- DIVU and REMU operands are unsigned.
- The quotient is negated if the operand signs differ.
- The remainder takes the sign of rs1.
REQ-023 Divide by zero SHALL still take the full latency and SHALL return:
- DIV and DIVU: 0xFFFFFFFF;
- REM and REMU: rs1_val.
REQ-024 Signed overflow (DIV or REM with 0x80000000 / 0xFFFFFFFF) SHALL return 0x80000000 for DIV and 0x00000000 for REM.
REQ-025 Latency SHALL be data-independent for all eight operations, with no early termination.

Reset
REQ-026 While reset is sampled high, the block SHALL set state to IDLE and clear counter, busy, done, result and rd_out to 0.
REQ-027 Reset SHALL override start and any in-progress operation, including in CALC and DONE; no done pulse SHALL follow an aborted operation.
REQ-028 If start and reset are high on the same edge, reset SHALL win and the request SHALL be dropped.

Verification
REQ-029 MUL with rs1=7 and rs2=0xFFFFFFFD (-3), start at edge N: busy is high after edges N..N+31, done is high after N+32, and result=0xFFFFFFEB.
REQ-030 Both operands 0xFFFFFFFF: MULHU gives 0xFFFFFFFE, MULH gives 0x00000000, MULHSU gives 0xFFFFFFFF and MUL gives 0x00000001.
REQ-031 rs1=0xFFFFFFF9 (-7), rs2=2: DIV gives 0xFFFFFFFD, REM gives 0xFFFFFFFF, DIVU gives 0x7FFFFFFC and REMU gives 0x00000001.
REQ-032 rs2=0 with rs1=5: DIVU gives 0xFFFFFFFF and REMU gives 5; rs1=0x80000000, rs2=0xFFFFFFFF: DIV gives 0x80000000 and REM gives 0.
REQ-033 Toggle start and the operands during CALC: no restart occurs and the original result is produced at N+32; rd_out equals the rd_in latched at N.
REQ-034 Assert reset at the 10th CALC cycle: the next cycle shows busy=0, done=0, result=0 and rd_out=0, no done pulse follows, and a fresh start is accepted afterwards.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative 32-bit RISC-V M-extension multiply/divide unit: one shift-add or
// restoring-divide step per cycle, fixed 32-cycle compute phase, one-cycle done pulse.
module muldiv_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] rs1_val,
    input  logic [31:0] rs2_val,
    input  logic [4:0]  rd_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [4:0]  rd_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [4:0]  count_reg;
    logic [2:0]  funct3_reg;
    logic        sign_a_reg, sign_b_reg;
    logic [31:0] mag_reg;      // multiplicand (mul) or divisor (div)
    logic [31:0] acc_reg;      // product high half (mul) or partial remainder (div)
    logic [31:0] lo_reg;       // multiplier/product low half (mul) or dividend/quotient (div)
    logic [31:0] result_reg;
    logic [4:0]  rd_reg;

    // Operand preparation at acceptance
    logic        in_is_div, in_signed_a, in_signed_b;
    logic        in_neg_a, in_neg_b;
    logic [31:0] in_mag_a, in_mag_b;

    always_comb begin
        in_is_div   = funct3[2];
        in_signed_a = in_is_div ? ~funct3[0] : (funct3[1:0] == 2'b01 || funct3[1:0] == 2'b10);
        in_signed_b = in_is_div ? ~funct3[0] : (funct3[1:0] == 2'b01);
        in_neg_a    = in_signed_a & rs1_val[31];
        in_neg_b    = in_signed_b & rs2_val[31];
        in_mag_a    = in_neg_a ? (~rs1_val + 32'd1) : rs1_val;
        in_mag_b    = in_neg_b ? (~rs2_val + 32'd1) : rs2_val;
    end

    // One iteration of each algorithm
    logic [32:0] mul_sum;
    logic [31:0] mul_acc, mul_lo;
    logic [32:0] div_shift, div_diff;
    logic [31:0] div_acc, div_lo;
    logic        is_div;
    logic [31:0] acc_step, lo_step;

    always_comb begin
        is_div    = funct3_reg[2];

        mul_sum   = {1'b0, acc_reg} + (lo_reg[0] ? {1'b0, mag_reg} : 33'd0);
        mul_acc   = mul_sum[32:1];
        mul_lo    = {mul_sum[0], lo_reg[31:1]};

        div_shift = {acc_reg, lo_reg[31]};
        div_diff  = div_shift - {1'b0, mag_reg};
        if (!div_diff[32]) begin
            div_acc = div_diff[31:0];
            div_lo  = {lo_reg[30:0], 1'b1};
        end else begin
            div_acc = div_shift[31:0];
            div_lo  = {lo_reg[30:0], 1'b0};
        end

        acc_step  = is_div ? div_acc : mul_acc;
        lo_step   = is_div ? div_lo  : mul_lo;
    end

    // Sign fix-up and result selection, evaluated on the final iteration's values
    logic [63:0] product, product_signed;
    logic [31:0] quot_final, rem_final, final_value;
    logic        div_by_zero;

    always_comb begin
        product        = {mul_acc, mul_lo};
        product_signed = (sign_a_reg ^ sign_b_reg) ? (~product + 64'd1) : product;
        div_by_zero    = (mag_reg == 32'd0);
        if (div_by_zero) begin
            quot_final = 32'hFFFF_FFFF;
        end else begin
            quot_final = (sign_a_reg ^ sign_b_reg) ? (~div_lo + 32'd1) : div_lo;
        end
        // Zero-divisor remainder falls out as |rs1| restored to rs1's sign
        rem_final      = sign_a_reg ? (~div_acc + 32'd1) : div_acc;
        if (is_div) begin
            final_value = funct3_reg[1] ? rem_final : quot_final;
        end else begin
            final_value = (funct3_reg[1:0] == 2'b00) ? product_signed[31:0] : product_signed[63:32];
        end
    end

    // Control FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (count_reg == 5'd31) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg  <= 5'd0;
            funct3_reg <= 3'd0;
            sign_a_reg <= 1'b0;
            sign_b_reg <= 1'b0;
            mag_reg    <= 32'd0;
            acc_reg    <= 32'd0;
            lo_reg     <= 32'd0;
            result_reg <= 32'd0;
            rd_reg     <= 5'd0;
        end else if (state_reg == IDLE && start) begin
            count_reg  <= 5'd0;
            funct3_reg <= funct3;
            sign_a_reg <= in_neg_a;
            sign_b_reg <= in_neg_b;
            acc_reg    <= 32'd0;
            rd_reg     <= rd_in;
            if (in_is_div) begin
                lo_reg  <= in_mag_a;
                mag_reg <= in_mag_b;
            end else begin
                lo_reg  <= in_mag_b;
                mag_reg <= in_mag_a;
            end
        end else if (state_reg == CALC) begin
            count_reg <= count_reg + 5'd1;
            acc_reg   <= acc_step;
            lo_reg    <= lo_step;
            if (count_reg == 5'd31) begin
                result_reg <= final_value;
            end
        end
    end

    assign result = result_reg;
    assign rd_out = rd_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: scoreboard of expected results, one task per scenario.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [4:0]  rd_in;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
    } exp_t;

    exp_t sb_q[$];

    typedef struct packed {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
    } vec_t;

    localparam int NVEC = 16;
    localparam vec_t VECS [0:NVEC-1] = '{
        '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB},
        '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
        '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000},
        '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
        '{3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001},
        '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD},
        '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF},
        '{3'd5, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC},
        '{3'd7, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001},
        '{3'd5, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF},
        '{3'd7, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005},
        '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
        '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000},
        '{3'd4, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFFF},
        '{3'd6, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9},
        '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000}
    };

    muldiv_unit dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .funct3  (funct3),
        .rs1_val (rs1_val),
        .rs2_val (rs2_val),
        .rd_in   (rd_in),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .rd_out  (rd_out)
    );

    always #5 clk = ~clk;

    // Arithmetic reference built on native 64-bit operators
    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        logic        ovf;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = 64'd0;
        case (f)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                p = $signed(sa) / $signed(sb);
                return p[31:0];
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (ovf) return 32'd0;
                p = $signed(sa) % $signed(sb);
                return p[31:0];
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    // Drive one request; expectation goes to the scoreboard, operands scrambled after acceptance
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] expv);
        exp_t e;
        e.res = expv;
        e.rd  = rd;
        sb_q.push_back(e);
        funct3  = f;
        rs1_val = a;
        rs2_val = b;
        rd_in   = rd;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        funct3  = 3'($urandom);
        rs1_val = $urandom;
        rs2_val = $urandom;
        rd_in   = 5'($urandom);
    endtask

    // Bounded wait for done; lat counts sampling cycles since the accepting edge
    task automatic wait_done(input bit toggle, output bit seen, output int lat, output int busy_cycles);
        seen        = 1'b0;
        lat         = 0;
        busy_cycles = 0;
        while (!seen && lat < 100) begin
            @(negedge clk);
            lat++;
            if (done) begin
                seen = 1'b1;
            end else begin
                if (busy) busy_cycles++;
                if (toggle) begin
                    start   = 1'($urandom);
                    funct3  = 3'($urandom);
                    rs1_val = $urandom;
                    rs2_val = $urandom;
                    rd_in   = 5'($urandom);
                end
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: busy=%b done=%b, expected 0 0", busy, done);
        end
        n_checks++;
        if (result !== 32'd0 || rd_out !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_data: result=%h rd_out=%0d, expected 0 0", result, rd_out);
        end
        start = 1'b0;
        reset = 1'b0;
        $display("reset: busy=%b done=%b result=%h rd_out=%0d", busy, done, result, rd_out);
    endtask

    task automatic test_mul_timing();
        bit   seen;
        int   lat, bc;
        exp_t e;
        @(negedge clk);
        issue(3'd0, 32'h7, 32'hFFFF_FFFD, 5'd9, 32'hFFFF_FFEB);
        wait_done(1'b0, seen, lat, bc);
        e = sb_q.pop_front();
        n_checks++;
        if (!seen || lat != 33) begin
            n_fail++;
            $display("FAIL mul_latency: done seen=%0b at cycle %0d, expected cycle 33", seen, lat);
        end
        n_checks++;
        if (bc != 32) begin
            n_fail++;
            $display("FAIL mul_busy_cycles: %0d, expected 32", bc);
        end
        n_checks++;
        if (result !== e.res || rd_out !== e.rd) begin
            n_fail++;
            $display("FAIL mul_result: result=%h rd=%0d, expected %h rd=%0d", result, rd_out, e.res, e.rd);
        end
        $display("mul 7*-3: result=%h rd_out=%0d latency=%0d busy_cycles=%0d", result, rd_out, lat, bc);
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0 || result !== e.res || rd_out !== e.rd) begin
                n_fail++;
                $display("FAIL hold_after_done: done=%b busy=%b result=%h rd=%0d, expected 0 0 %h %0d",
                         done, busy, result, rd_out, e.res, e.rd);
            end
        end
    endtask

    task automatic test_vectors();
        bit   seen;
        int   lat, bc;
        exp_t e;
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            issue(VECS[i].f, VECS[i].a, VECS[i].b, 5'(i + 1), VECS[i].r);
            wait_done(1'b0, seen, lat, bc);
            e = sb_q.pop_front();
            n_checks++;
            if (!seen || result !== e.res) begin
                n_fail++;
                $display("FAIL vector_%0d f=%0d a=%h b=%h: result=%h seen=%0b, expected %h",
                         i, VECS[i].f, VECS[i].a, VECS[i].b, result, seen, e.res);
            end
            n_checks++;
            if (rd_out !== e.rd || lat != 33) begin
                n_fail++;
                $display("FAIL vector_%0d_rd_lat: rd=%0d lat=%0d, expected rd=%0d lat=33", i, rd_out, lat, e.rd);
            end
            $display("vector %0d f=%0d a=%h b=%h result=%h rd_out=%0d lat=%0d",
                     i, VECS[i].f, VECS[i].a, VECS[i].b, result, rd_out, lat);
        end
    endtask

    task automatic test_ignore_during_calc();
        bit   seen;
        int   lat, bc;
        exp_t e;
        @(negedge clk);
        issue(3'd4, 32'hFFFF_FFF9, 32'h2, 5'd17, 32'hFFFF_FFFD);
        wait_done(1'b1, seen, lat, bc);
        e = sb_q.pop_front();
        n_checks++;
        if (!seen || lat != 33 || bc != 32) begin
            n_fail++;
            $display("FAIL toggle_timing: seen=%0b lat=%0d busy=%0d, expected 1 33 32", seen, lat, bc);
        end
        n_checks++;
        if (result !== e.res || rd_out !== e.rd) begin
            n_fail++;
            $display("FAIL toggle_result: result=%h rd=%0d, expected %h rd=%0d", result, rd_out, e.res, e.rd);
        end
        $display("toggle during calc: result=%h rd_out=%0d lat=%0d", result, rd_out, lat);
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL toggle_no_restart: busy=%b, expected 0", busy);
        end
    endtask

    task automatic test_reset_abort();
        bit   seen;
        int   lat, bc, done_count;
        exp_t e;
        @(negedge clk);
        issue(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 5'd21, 32'd0);
        void'(sb_q.pop_back());
        repeat (10) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_busy_before: busy=%b, expected 1", busy);
        end
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0 || rd_out !== 5'd0) begin
            n_fail++;
            $display("FAIL abort_cleared: busy=%b done=%b result=%h rd=%0d, expected all 0",
                     busy, done, result, rd_out);
        end
        reset = 1'b0;
        done_count = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) done_count++;
        end
        n_checks++;
        if (done_count != 0) begin
            n_fail++;
            $display("FAIL abort_no_done: %0d active cycles after abort, expected 0", done_count);
        end
        $display("abort at calc cycle 10: quiet cycles checked, active=%0d", done_count);
        issue(3'd3, 32'hDEAD_BEEF, 32'h0000_1000, 5'd3, ref_model(3'd3, 32'hDEAD_BEEF, 32'h0000_1000));
        wait_done(1'b0, seen, lat, bc);
        e = sb_q.pop_front();
        n_checks++;
        if (!seen || lat != 33 || result !== e.res || rd_out !== e.rd) begin
            n_fail++;
            $display("FAIL abort_restart: seen=%0b lat=%0d result=%h rd=%0d, expected 1 33 %h %0d",
                     seen, lat, result, rd_out, e.res, e.rd);
        end
        $display("restart after abort: result=%h rd_out=%0d", result, rd_out);
    endtask

    task automatic test_start_with_reset();
        int active;
        @(negedge clk);
        reset   = 1'b1;
        start   = 1'b1;
        funct3  = 3'd0;
        rs1_val = 32'd3;
        rs2_val = 32'd4;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        active = 0;
        repeat (40) begin
            if (busy || done) active++;
            @(negedge clk);
        end
        n_checks++;
        if (active != 0) begin
            n_fail++;
            $display("FAIL start_with_reset: %0d active cycles, expected 0", active);
        end
        $display("start with reset: active=%0d", active);
    endtask

    task automatic test_back_to_back();
        bit   seen;
        int   lat, bc;
        exp_t e, e2;
        @(negedge clk);
        issue(3'd5, 32'd100, 32'd7, 5'd11, 32'd14);
        wait_done(1'b0, seen, lat, bc);
        e = sb_q.pop_front();
        n_checks++;
        if (!seen || result !== e.res || rd_out !== e.rd) begin
            n_fail++;
            $display("FAIL b2b_first: result=%h rd=%0d, expected %h %0d", result, rd_out, e.res, e.rd);
        end
        e2.res  = ref_model(3'd7, 32'd100, 32'd7);
        e2.rd   = 5'd12;
        sb_q.push_back(e2);
        funct3  = 3'd7;
        rs1_val = 32'd100;
        rs2_val = 32'd7;
        rd_in   = 5'd12;
        start   = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_not_in_done: busy=%b done=%b, expected 0 0", busy, done);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(1'b0, seen, lat, bc);
        e = sb_q.pop_front();
        n_checks++;
        if (!seen || lat != 33 || bc != 32 || result !== e.res || rd_out !== e.rd) begin
            n_fail++;
            $display("FAIL b2b_second: seen=%0b lat=%0d busy=%0d result=%h rd=%0d, expected 1 33 32 %h %0d",
                     seen, lat, bc, result, rd_out, e.res, e.rd);
        end
        $display("back-to-back: second result=%h rd_out=%0d lat=%0d", result, rd_out, lat);
    endtask

    task automatic test_random();
        bit          seen;
        int          lat, bc;
        exp_t        e;
        logic [2:0]  f;
        logic [31:0] a, b;
        logic [31:0] picks [5];
        picks[0] = 32'd0;
        picks[1] = 32'd1;
        picks[2] = 32'hFFFF_FFFF;
        picks[3] = 32'h8000_0000;
        picks[4] = 32'h7FFF_FFFF;
        for (int i = 0; i < 24; i++) begin
            f = 3'($urandom);
            a = ($urandom_range(0, 3) == 0) ? picks[$urandom_range(0, 4)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? picks[$urandom_range(0, 4)] : $urandom;
            if (i % 5 == 0) b = b & 32'h0000_00FF;
            @(negedge clk);
            issue(f, a, b, 5'(i), ref_model(f, a, b));
            wait_done(1'b0, seen, lat, bc);
            e = sb_q.pop_front();
            n_checks++;
            if (!seen || lat != 33 || result !== e.res || rd_out !== e.rd) begin
                n_fail++;
                $display("FAIL random_%0d f=%0d a=%h b=%h: result=%h rd=%0d lat=%0d, expected %h %0d 33",
                         i, f, a, b, result, rd_out, lat, e.res, e.rd);
            end
            $display("random %0d f=%0d a=%h b=%h result=%h rd_out=%0d", i, f, a, b, result, rd_out);
        end
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        funct3  = 3'd0;
        rs1_val = 32'd0;
        rs2_val = 32'd0;
        rd_in   = 5'd0;
        test_reset();
        test_mul_timing();
        test_vectors();
        test_ignore_during_calc();
        test_reset_abort();
        test_start_with_reset();
        test_back_to_back();
        test_random();
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
